// File: rtl/digit_serial_addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_serial_pkg                                                   |
// | FSM state encoding and sizing helpers for digit_serial_addsub.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package digit_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter only has to reach NDIG-1; keep at least one bit.
  function automatic int cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_addsub_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_serial_addsub_if                                             |
// | Start/ready/done request bus with operands, result and flags.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;

  modport master (
    output start_i, sub_i, a_i, b_i, cin_i,
    input  ready_o, done_o, sum_o, cout_o, ovf_o, zero_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i, cin_i,
    output ready_o, done_o, sum_o, cout_o, ovf_o, zero_o
  );
endinterface
`default_nettype wire

// File: rtl/digit_serial_addsub_cpa_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpa_slice                                                          |
// | DIGIT-bit combinational ripple adder built from full-adder cells.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cpa_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout     = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_serial_addsub                                                |
// | Multi-cycle add/sub, DIGIT bits per clock with registered carry.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("digit_serial_addsub: DIGIT must be in 1..WIDTH and divide WIDTH (WIDTH>=2)");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [DIGIT-1:0]       w_s;
  logic                   w_cout;
  logic                   w_cmsb;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_acc_next;
  logic                   w_last;
  logic                   w_accept;

  cpa_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (r_a[DIGIT-1:0]),
    .b        (r_b[DIGIT-1:0]),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // New digit enters at the top; after NDIG shifts the LSB digit lands at bit 0.
  assign w_cat      = {w_s, r_acc};
  assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last     = (r_cnt == CW'(NDIG - 1));
  assign w_accept   = (r_state == ST_IDLE) && bus.start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start_i) w_next = ST_RUN;
      ST_RUN:  if (w_last)      w_next = ST_DONE;
      ST_DONE:                  w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (r_state == ST_IDLE);
    bus.done_o  = (r_state == ST_DONE);
    bus.sum_o   = r_sum;
    bus.cout_o  = r_cout;
    bus.ovf_o   = r_ovf;
    bus.zero_o  = r_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + ~borrow_in.
      r_a     <= bus.a_i;
      r_b     <= bus.sub_i ? ~bus.b_i : bus.b_i;
      r_carry <= bus.cin_i ^ bus.sub_i;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_next;
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_cout;
        r_ovf  <= w_cmsb ^ w_cout;
        r_zero <= (w_acc_next == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_digit_serial_addsub                                             |
// | Directed and randomised checks over six WIDTH/DIGIT configurations.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_digit_serial_addsub;

  localparam int NCFG   = 6;
  localparam int NRAND  = 1000;

  function automatic int cfg_w(input int k);
    return (k == 5) ? 12 : 16;
  endfunction

  function automatic int cfg_d(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      4:       return 16;
      default: return 3;
    endcase
  endfunction

  logic clk;
  logic rst_n;

  logic        sw_start [NCFG];
  logic        sw_sub   [NCFG];
  logic        sw_cin   [NCFG];
  logic [15:0] sw_a     [NCFG];
  logic [15:0] sw_b     [NCFG];
  logic        sw_ready [NCFG];
  logic        sw_done  [NCFG];
  logic [15:0] sw_sum   [NCFG];
  logic        sw_cout  [NCFG];
  logic        sw_ovf   [NCFG];
  logic        sw_zero  [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int W = cfg_w(k);
    localparam int D = cfg_d(k);

    digit_serial_addsub_if #(.WIDTH(W)) bus ();

    assign bus.start_i = sw_start[k];
    assign bus.sub_i   = sw_sub[k];
    assign bus.cin_i   = sw_cin[k];
    assign bus.a_i     = sw_a[k][W-1:0];
    assign bus.b_i     = sw_b[k][W-1:0];

    digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    assign sw_ready[k] = bus.ready_o;
    assign sw_done[k]  = bus.done_o;
    assign sw_sum[k]   = 16'(bus.sum_o);
    assign sw_cout[k]  = bus.cout_o;
    assign sw_ovf[k]   = bus.ovf_o;
    assign sw_zero[k]  = bus.zero_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, signed range test for overflow.
  function automatic void model(input int w, input bit sub, input logic [15:0] a,
                                input logic [15:0] b, input bit cin,
                                output logic [15:0] s, output bit co, output bit ov,
                                output bit z);
    longint md, ua, ub, sa, sb, r, sr;
    md = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (!sub) begin
      r  = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      co = (r >= md);
    end else begin
      r  = ua - ub - longint'(cin);
      sr = sa - sb - longint'(cin);
      co = (r >= 0);
    end
    s  = 16'(r & (md - 1));
    ov = (sr < -(md / 2)) || (sr > md / 2 - 1);
    z  = (s == 16'd0);
  endfunction

  task automatic scramble(input int k);
    sw_a[k]   = 16'($urandom);
    sw_b[k]   = 16'($urandom);
    sw_sub[k] = 1'($urandom);
    sw_cin[k] = 1'($urandom);
  endtask

  // Called #1 after an edge with the instance idle; returns after the cycle following done.
  task automatic run_op(input int k, input bit sub, input logic [15:0] a_in,
                        input logic [15:0] b_in, input bit cin);
    int          w;
    int          nd;
    int          lat;
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] es;
    bit          eco, eov, ez;
    w    = cfg_w(k);
    nd   = w / cfg_d(k);
    mask = 16'((32'd1 << w) - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    model(w, sub, a, b, cin, es, eco, eov, ez);
    sw_sub[k]   = sub;
    sw_a[k]     = a;
    sw_b[k]     = b;
    sw_cin[k]   = cin;
    sw_start[k] = 1'b1;
    @(posedge clk); #1;
    sw_start[k] = 1'b0;
    scramble(k);
    lat = 0;
    for (int c = 1; c <= nd + 3 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (sw_done[k]) lat = c;
      else scramble(k);
    end
    chk($sformatf("latency cfg%0d", k), lat, nd);
    chk($sformatf("sum cfg%0d", k),  sw_sum[k],  es);
    chk($sformatf("cout cfg%0d", k), sw_cout[k], eco);
    chk($sformatf("ovf cfg%0d", k),  sw_ovf[k],  eov);
    chk($sformatf("zero cfg%0d", k), sw_zero[k], ez);
    chk($sformatf("ready_in_done cfg%0d", k), sw_ready[k], 1'b0);
    @(posedge clk); #1;
    chk($sformatf("done_one_cycle cfg%0d", k), sw_done[k], 1'b0);
    chk($sformatf("ready_back cfg%0d", k), sw_ready[k], 1'b1);
    chk($sformatf("sum_hold cfg%0d", k), sw_sum[k], es);
  endtask

  initial begin
    int ndone;
    int first;
    int second;
    int wait_c;
    logic [15:0] first_sum;

    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      sw_start[k] = 1'b0;
      sw_sub[k]   = 1'b0;
      sw_cin[k]   = 1'b0;
      sw_a[k]     = 16'd0;
      sw_b[k]     = 16'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state on every configuration
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("rst_ready cfg%0d", k), sw_ready[k], 1'b1);
      chk($sformatf("rst_done cfg%0d", k),  sw_done[k],  1'b0);
      chk($sformatf("rst_sum cfg%0d", k),   sw_sum[k],   16'd0);
      chk($sformatf("rst_flags cfg%0d", k), {sw_cout[k], sw_ovf[k], sw_zero[k]}, 3'b000);
    end

    // Directed cases with independently stated results
    run_op(0, 1'b0, 16'h1234, 16'h0FED, 1'b0);
    chk("dir_add_sum", sw_sum[0], 16'h2221);
    chk("dir_add_flags", {sw_cout[0], sw_ovf[0], sw_zero[0]}, 3'b000);
    run_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk("dir_add_ovf", {sw_sum[0], sw_cout[0], sw_ovf[0], sw_zero[0]}, {16'h8000, 3'b010});
    run_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    chk("dir_add_wrap", {sw_sum[0], sw_cout[0], sw_ovf[0], sw_zero[0]}, {16'h0000, 3'b101});
    run_op(0, 1'b1, 16'h0005, 16'h0007, 1'b0);
    chk("dir_sub_borrow", {sw_sum[0], sw_cout[0], sw_ovf[0]}, {16'hFFFE, 2'b00});
    run_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0);
    chk("dir_sub_ovf", {sw_sum[0], sw_cout[0], sw_ovf[0]}, {16'h7FFF, 2'b11});
    run_op(0, 1'b1, 16'h0010, 16'h0001, 1'b1);
    chk("dir_sub_bin", sw_sum[0], 16'h000E);

    // start held high: one op per NDIG+2 cycles, mid-RUN operand changes ignored
    sw_a[0] = 16'h1111; sw_b[0] = 16'h2222; sw_sub[0] = 1'b0; sw_cin[0] = 1'b0;
    sw_start[0] = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = 0; second = 0; first_sum = 16'd0;
    for (int c = 1; c <= 12; c++) begin
      sw_a[0] = 16'($urandom); sw_b[0] = 16'($urandom);
      @(posedge clk); #1;
      if (sw_done[0]) begin
        ndone++;
        if (first == 0) begin first = c; first_sum = sw_sum[0]; end
        else if (second == 0) second = c;
      end
    end
    chk("hold_ndone", ndone, 2);
    chk("hold_first", first, 4);
    chk("hold_second", second, 10);
    chk("hold_sum", first_sum, 16'h3333);
    sw_start[0] = 1'b0;
    wait_c = 0;
    while (!sw_ready[0] && wait_c < 20) begin
      @(posedge clk); #1;
      wait_c++;
    end
    chk("hold_drain_ready", sw_ready[0], 1'b1);

    // Asynchronous reset in the middle of RUN
    run_op(0, 1'b0, 16'h1234, 16'h0FED, 1'b0);
    sw_a[0] = 16'h4321; sw_b[0] = 16'h1111; sw_sub[0] = 1'b0; sw_cin[0] = 1'b0;
    sw_start[0] = 1'b1;
    @(posedge clk); #1;
    sw_start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", sw_ready[0], 1'b1);
    chk("midrst_done", sw_done[0], 1'b0);
    chk("midrst_sum", sw_sum[0], 16'd0);
    chk("midrst_flags", {sw_cout[0], sw_ovf[0], sw_zero[0]}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (sw_done[0]) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Randomised sweep across all configurations
    for (int k = 0; k < NCFG; k++) begin
      for (int i = 0; i < NRAND; i++) begin
        run_op(k, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, multi-cycle successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple slice and a registered carry between digits. Width and area are traded against latency. It produces the sum, carry/borrow, signed overflow and zero flags behind a start/ready/done handshake, and serves as the arithmetic unit for datapaths too wide for a single-cycle ripple chain.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 2.
- DIGIT, 4: bits processed per cycle.
  - Must be in 1..WIDTH and must divide WIDTH.
  - NDIG = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; accepted only when ready_o=1.
- sub_i  in  1  0: A+B+cin; 1: A−B−cin (cin acts as borrow-in).
- a_i  in  WIDTH  operand A; sampled only at accept.
- b_i  in  WIDTH  operand B; sampled only at accept.
- cin_i  in  1  carry-in (add) or borrow-in (sub); sampled at accept.
- ready_o  out  1  block idle and able to accept.
- done_o  out  1  one-cycle pulse; results valid.
- sum_o  out  WIDTH  result, two's-complement wrap.
- cout_o  out  1  raw carry out of MSB; for sub, 1 = no borrow.
- ovf_o  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero_o  out  1  sum_o == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_o=1. On start_i=1:
  - latch A into the operand register.
  - latch B, or ~B when sub_i=1.
  - carry register ← cin_i XOR sub_i.
  - digit counter ← 0.
  - go to RUN.
- RUN: on each edge, the DIGIT-bit slice adds the low DIGIT bits of the A and B registers plus the carry.
  - Slice sum shifts into the top of the sum register (shift right by DIGIT).
  - A and B shift right by DIGIT.
  - Carry register ← slice carry-out.
  - Carry into the slice MSB is captured for overflow.
  - Counter increments.
  - On the edge processing digit NDIG−1: go to DONE and register cout/ovf/zero.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- sum_o, cout_o, ovf_o and zero_o hold their values from DONE until the next accepted start.
  - They are not updated during RUN; the shadow sum register is internal.
- start_i while ready_o=0 (RUN or DONE) is ignored; it is neither queued nor flagged.
- sub_i, a_i, b_i and cin_i are don't-care outside the accept cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - FSM → IDLE; ready_o=1.
  - done_o, sum_o, cout_o, ovf_o, zero_o = 0.
  - Internal registers cleared.
  - An operation in flight is discarded and no done_o is produced for it.
- DIGIT=WIDTH: NDIG=1, a single RUN cycle.
- DIGIT=1: bit-serial operation.

## Timing
- Accept edge E0 (start_i=1 and ready_o=1).
- RUN occupies edges E1..E_NDIG.
- done_o is high between E_NDIG and E_NDIG+1.
- ready_o returns to 1 after E_NDIG+1.
- Latency from accept to done is NDIG cycles. Initiation interval is NDIG+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Critical path is one DIGIT-bit ripple plus the carry register setup.

## Structure
- Package digit_serial_pkg holds:
  - state enum (IDLE, RUN, DONE).
  - constant-function helper for NDIG and counter width, $clog2(NDIG) with a minimum of 1.
- Sub-module cpa_slice: parametrised DIGIT-bit combinational ripple adder.
  - Ports: a, b, cin → s, cout, c_msb_in.
  - Built from full-adder bit cells.
- The top level holds the FSM, counter, shift registers and flag logic.
- Elaboration-time assertion fails if DIGIT does not divide WIDTH.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
- Reset asserted then released → sum_o=0, flags 0, done_o=0, ready_o=1.
- Add 0x1234+0x0FED with cin=0, start at E0 → done_o at E4 only; sum_o=0x2221, cout=0, ovf=0, zero=0.
- Add 0x7FFF+0x0001 → 0x8000, ovf=1, cout=0. Add 0xFFFF+0x0001 → 0x0000, cout=1, zero=1, ovf=0.
- Sub 0x0005−0x0007 with cin=0 → 0xFFFE, cout=0 (borrow), ovf=0. Sub 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1. Sub 0x0010−0x0001 with cin=1 → 0x000E.
- Protocol and reset:
  - start_i held high through RUN/DONE → exactly one operation per NDIG+2 cycles; operands change mid-RUN without affecting the result.
  - rst_n pulsed low at RUN digit 2 → immediate IDLE, outputs 0, no done_o.
- Parameter sweep: DIGIT ∈ {1, 2, 8, 16} with WIDTH=16, plus WIDTH=12 with DIGIT=3.
  - 1000 random add/sub ops each, checked against a behavioural model.
  - done_o must arrive exactly NDIG cycles after accept.
